// File: rtl/dma_cpu_reg_if.sv
// rtl/dma_cpu_reg_if.sv - CPU-side register interface for an 8237A-compatible DMA controller
//
// Decodes host I/O read/write cycles into the DMA register file and merges
// current address/count/TC updates coming from the DMA timing core.
//
// Ports:
//   CLK, RESET_N          clock, asynchronous active-low reset
//   CS_N, IOR_N, IOW_N    host chip select and read/write strobes (active low)
//   A, DB_IN              host register address and write data
//   DB_OUT, DB_OE         host read data and its drive enable
//   dreq_in               DREQ levels reported in STATUS[7:4]
//   tc_pulse              per-channel terminal-count event from the core
//   temp_data             temporary data register from the core
//   upd_valid/ch/addr/count  core load of the current address/count registers
//   cmd_reg, mode_reg, mask_reg, req_reg    exported control registers
//   base_addr, base_count, curr_addr, curr_count  exported 16-bit per-channel registers
//   master_clear          one-cycle pulse after a master-clear command
module dma_cpu_reg_if #(
    parameter int NUM_CH = 4,
    parameter int AW     = 16
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 CS_N,
    input  logic                 IOR_N,
    input  logic                 IOW_N,
    input  logic [3:0]           A,
    input  logic [7:0]           DB_IN,
    output logic [7:0]           DB_OUT,
    output logic                 DB_OE,
    input  logic [NUM_CH-1:0]    dreq_in,
    input  logic [NUM_CH-1:0]    tc_pulse,
    input  logic [7:0]           temp_data,
    input  logic                 upd_valid,
    input  logic [1:0]           upd_ch,
    input  logic [AW-1:0]        upd_addr,
    input  logic [AW-1:0]        upd_count,
    output logic [7:0]           cmd_reg,
    output logic [6*NUM_CH-1:0]  mode_reg,
    output logic [NUM_CH-1:0]    mask_reg,
    output logic [NUM_CH-1:0]    req_reg,
    output logic [AW*NUM_CH-1:0] base_addr,
    output logic [AW*NUM_CH-1:0] base_count,
    output logic [AW*NUM_CH-1:0] curr_addr,
    output logic [AW*NUM_CH-1:0] curr_count,
    output logic                 master_clear
);

    logic              wr_cycle;
    logic              rd_cycle;
    logic              iow_q;
    logic              ior_q;
    logic              wr_pend;
    logic              rd_pend;
    logic [3:0]        wa;
    logic [7:0]        wd;
    logic [3:0]        ra;
    logic              wr_commit;
    logic              rd_done;
    logic              wr_ac;
    logic              ff;
    logic              ff_d;
    logic [NUM_CH-1:0] tc_q;
    logic [NUM_CH-1:0] tc_d;
    logic [NUM_CH-1:0] mask_d;
    logic [NUM_CH-1:0] req_d;
    logic [5:0]        wr_bidx;
    logic [5:0]        upd_idx;
    logic [5:0]        rd_idx;
    logic              upd_hit_addr;
    logic              upd_hit_count;
    logic [AW-1:0]     rd_word;

    assign wr_cycle = !CS_N && !IOW_N && IOR_N;
    assign rd_cycle = !CS_N && !IOR_N && IOW_N;

    // A pending flag records that a qualified cycle was actually sampled, so a
    // strobe already low when reset releases cannot produce a commit.
    assign wr_commit = wr_pend && !iow_q && IOW_N;
    assign rd_done   = rd_pend && !ior_q && IOR_N;
    assign wr_ac     = wr_commit && !wa[3];

    // Byte offset inside the packed 64-bit vectors: channel*16 + byte*8
    assign wr_bidx = {wa[2:1], ff, 3'b000};
    assign upd_idx = {upd_ch, 4'b0000};
    assign rd_idx  = {A[2:1], 4'b0000};

    // A CPU byte write to the register the core is also loading keeps the CPU value
    assign upd_hit_addr  = wr_ac && !wa[0] && (wa[2:1] == upd_ch);
    assign upd_hit_count = wr_ac &&  wa[0] && (wa[2:1] == upd_ch);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            iow_q   <= 1'b1;
            ior_q   <= 1'b1;
            wr_pend <= 1'b0;
            rd_pend <= 1'b0;
            wa      <= 4'h0;
            wd      <= 8'h00;
            ra      <= 4'h0;
        end else begin
            iow_q <= IOW_N;
            ior_q <= IOR_N;
            if (wr_cycle) begin
                wa      <= A;
                wd      <= DB_IN;
                wr_pend <= 1'b1;
            end else if (wr_commit) begin
                wr_pend <= 1'b0;
            end
            if (rd_cycle) begin
                ra      <= A;
                rd_pend <= 1'b1;
            end else if (rd_done) begin
                rd_pend <= 1'b0;
            end
        end
    end

    // Mask/request/TC next state: later assignments take priority, giving
    // master clear > CPU write > tc_pulse, and a TC set beats the status-read clear.
    always_comb begin
        mask_d = mask_reg;
        req_d  = req_reg;
        tc_d   = tc_q;
        ff_d   = ff;
        if (rd_done && (ra == 4'h8)) begin
            tc_d = '0;
        end
        if (rd_done && !ra[3]) begin
            ff_d = ~ff;
        end
        for (int n = 0; n < NUM_CH; n++) begin
            if (tc_pulse[n]) begin
                tc_d[n] = 1'b1;
                // MODE[4] (auto-init) sits at offset 2 of the stored MODE[7:2] field
                if (!mode_reg[6*n+2]) begin
                    mask_d[n] = 1'b1;
                    req_d[n]  = 1'b0;
                end
            end
        end
        if (wr_commit) begin
            if (!wa[3]) begin
                ff_d = ~ff;
            end
            case (wa)
                4'h9: req_d[wd[1:0]]  = wd[2];
                4'hA: mask_d[wd[1:0]] = wd[2];
                4'hC: ff_d = 1'b0;
                4'hD: begin
                    mask_d = '1;
                    req_d  = '0;
                    tc_d   = '0;
                    ff_d   = 1'b0;
                end
                4'hE: mask_d = '0;
                4'hF: mask_d = wd[NUM_CH-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cmd_reg      <= 8'h00;
            mode_reg     <= '0;
            mask_reg     <= '1;
            req_reg      <= '0;
            tc_q         <= '0;
            ff           <= 1'b0;
            master_clear <= 1'b0;
        end else begin
            mask_reg     <= mask_d;
            req_reg      <= req_d;
            tc_q         <= tc_d;
            ff           <= ff_d;
            master_clear <= wr_commit && (wa == 4'hD);
            if (wr_commit && (wa == 4'h8)) begin
                cmd_reg <= wd;
            end
            if (wr_commit && (wa == 4'hD)) begin
                cmd_reg <= 8'h00;
            end
            if (wr_commit && (wa == 4'hB)) begin
                for (int n = 0; n < NUM_CH; n++) begin
                    if (wd[1:0] == n[1:0]) begin
                        mode_reg[6*n +: 6] <= wd[7:2];
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            base_addr  <= '0;
            base_count <= '0;
            curr_addr  <= '0;
            curr_count <= '0;
        end else begin
            if (upd_valid) begin
                if (!upd_hit_addr) begin
                    curr_addr[upd_idx +: AW] <= upd_addr;
                end
                if (!upd_hit_count) begin
                    curr_count[upd_idx +: AW] <= upd_count;
                end
            end
            if (wr_ac) begin
                if (!wa[0]) begin
                    base_addr[wr_bidx +: 8] <= wd;
                    curr_addr[wr_bidx +: 8] <= wd;
                end else begin
                    base_count[wr_bidx +: 8] <= wd;
                    curr_count[wr_bidx +: 8] <= wd;
                end
            end
        end
    end

    assign DB_OE = rd_cycle;

    always_comb begin
        rd_word = A[0] ? curr_count[rd_idx +: AW] : curr_addr[rd_idx +: AW];
        DB_OUT  = 8'h00;
        if (rd_cycle) begin
            if (!A[3]) begin
                DB_OUT = ff ? rd_word[15:8] : rd_word[7:0];
            end else if (A == 4'h8) begin
                DB_OUT = {dreq_in, tc_q};
            end else if (A == 4'hD) begin
                DB_OUT = temp_data;
            end
        end
    end

endmodule

// File: tb/tb_dma_cpu_reg_if.sv
// tb/tb_dma_cpu_reg_if.sv - scoreboard testbench for dma_cpu_reg_if
module tb_dma_cpu_reg_if;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        CS_N, IOR_N, IOW_N;
    logic [3:0]  A;
    logic [7:0]  DB_IN;
    logic [7:0]  DB_OUT;
    logic        DB_OE;
    logic [3:0]  dreq_in, tc_pulse;
    logic [7:0]  temp_data;
    logic        upd_valid;
    logic [1:0]  upd_ch;
    logic [15:0] upd_addr, upd_count;
    logic [7:0]  cmd_reg;
    logic [23:0] mode_reg;
    logic [3:0]  mask_reg, req_reg;
    logic [63:0] base_addr, base_count, curr_addr, curr_count;
    logic        master_clear;

    always #5 CLK = ~CLK;

    dma_cpu_reg_if dut (
        .CLK(CLK), .RESET_N(RESET_N), .CS_N(CS_N), .IOR_N(IOR_N), .IOW_N(IOW_N),
        .A(A), .DB_IN(DB_IN), .DB_OUT(DB_OUT), .DB_OE(DB_OE),
        .dreq_in(dreq_in), .tc_pulse(tc_pulse), .temp_data(temp_data),
        .upd_valid(upd_valid), .upd_ch(upd_ch), .upd_addr(upd_addr), .upd_count(upd_count),
        .cmd_reg(cmd_reg), .mode_reg(mode_reg), .mask_reg(mask_reg), .req_reg(req_reg),
        .base_addr(base_addr), .base_count(base_count), .curr_addr(curr_addr),
        .curr_count(curr_count), .master_clear(master_clear)
    );

    typedef struct {
        logic [7:0]  cmd;
        logic [23:0] mode;
        logic [3:0]  mask;
        logic [3:0]  req;
        logic [63:0] ba, bc, ca, cc;
        logic        mc;
    } snap_t;

    snap_t      exp_snap_q[$];
    logic [7:0] exp_rd_q[$];
    int tests = 0;
    int fails = 0;
    int chk_req_n = 0;
    int chk_done_n = 0;
    int rd_issued = 0;
    int rd_seen = 0;
    bit rd_armed = 0;

    // Reference model: the register file as plain per-channel words
    logic [15:0] m_ba[4], m_bc[4], m_ca[4], m_cc[4];
    logic [7:0]  m_cmd;
    logic [5:0]  m_mode[4];
    logic [3:0]  m_mask, m_req, m_tc;
    bit          m_ff, m_mc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 4; n++) begin
            m_ba[n] = 0; m_bc[n] = 0; m_ca[n] = 0; m_cc[n] = 0; m_mode[n] = 0;
        end
        m_cmd = 0; m_mask = 4'hF; m_req = 0; m_tc = 0; m_ff = 0; m_mc = 0;
    endtask

    task automatic model_write(input logic [3:0] a, input logic [7:0] d);
        int ch;
        ch = int'(a[2:1]);
        if (a < 4'h8) begin
            if (!a[0]) begin
                if (m_ff) begin m_ba[ch][15:8] = d; m_ca[ch][15:8] = d; end
                else      begin m_ba[ch][7:0]  = d; m_ca[ch][7:0]  = d; end
            end else begin
                if (m_ff) begin m_bc[ch][15:8] = d; m_cc[ch][15:8] = d; end
                else      begin m_bc[ch][7:0]  = d; m_cc[ch][7:0]  = d; end
            end
            m_ff = !m_ff;
        end else begin
            case (a)
                4'h8: m_cmd = d;
                4'h9: m_req[d[1:0]] = d[2];
                4'hA: m_mask[d[1:0]] = d[2];
                4'hB: m_mode[d[1:0]] = d[7:2];
                4'hC: m_ff = 0;
                4'hD: begin m_cmd = 0; m_req = 0; m_tc = 0; m_mask = 4'hF; m_ff = 0; m_mc = 1; end
                4'hE: m_mask = 4'h0;
                default: m_mask = d[3:0];
            endcase
        end
    endtask

    task automatic model_read(input logic [3:0] a, output logic [7:0] r);
        logic [15:0] w;
        int ch;
        ch = int'(a[2:1]);
        if (a < 4'h8) begin
            w = a[0] ? m_cc[ch] : m_ca[ch];
            r = m_ff ? w[15:8] : w[7:0];
            m_ff = !m_ff;
        end else if (a == 4'h8) begin
            r = {dreq_in, m_tc};
            m_tc = 0;
        end else if (a == 4'hD) begin
            r = temp_data;
        end else begin
            r = 8'h00;
        end
    endtask

    task automatic model_tc(input logic [3:0] v);
        for (int n = 0; n < 4; n++) begin
            if (v[n]) begin
                m_tc[n] = 1;
                if (!m_mode[n][2]) begin m_mask[n] = 1; m_req[n] = 0; end
            end
        end
    endtask

    task automatic push_check();
        snap_t s;
        s.cmd = m_cmd; s.mask = m_mask; s.req = m_req; s.mc = m_mc;
        for (int n = 0; n < 4; n++) begin
            s.mode[6*n +: 6] = m_mode[n];
            s.ba[16*n +: 16] = m_ba[n];
            s.bc[16*n +: 16] = m_bc[n];
            s.ca[16*n +: 16] = m_ca[n];
            s.cc[16*n +: 16] = m_cc[n];
        end
        m_mc = 0;
        exp_snap_q.push_back(s);
        chk_req_n++;
        @(negedge CLK);
        #1;
    endtask

    // Monitor: reads are scored when DB_OE is presented; register snapshots when requested
    always @(negedge CLK) begin
        logic [7:0] e;
        snap_t s;
        if (DB_OE && !rd_armed) begin
            rd_armed = 1;
            rd_seen++;
            if (exp_rd_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL rd_unexpected: got DB_OE=1 expected no read at %0t", $time);
            end else begin
                e = exp_rd_q.pop_front();
                chk("rd_data", {56'h0, DB_OUT}, {56'h0, e});
            end
        end else if (!DB_OE) begin
            rd_armed = 0;
        end
        if (chk_done_n < chk_req_n) begin
            s = exp_snap_q.pop_front();
            chk("cmd_reg", {56'h0, cmd_reg}, {56'h0, s.cmd});
            chk("mode_reg", {40'h0, mode_reg}, {40'h0, s.mode});
            chk("mask_reg", {60'h0, mask_reg}, {60'h0, s.mask});
            chk("req_reg", {60'h0, req_reg}, {60'h0, s.req});
            chk("base_addr", base_addr, s.ba);
            chk("base_count", base_count, s.bc);
            chk("curr_addr", curr_addr, s.ca);
            chk("curr_count", curr_count, s.cc);
            chk("master_clear", {63'h0, master_clear}, {63'h0, s.mc});
            chk("db_oe_idle", {63'h0, DB_OE}, 64'h0);
            chk_done_n++;
        end
    end

    task automatic do_write(input logic [3:0] a, input logic [7:0] d, input bit upd,
                            input logic [1:0] uch, input logic [15:0] ua, input logic [15:0] uc);
        @(posedge CLK); #2;
        CS_N = 0; A = a; DB_IN = d; IOW_N = 0;
        repeat (2) @(posedge CLK);
        #2;
        IOW_N = 1; CS_N = 1; A = 4'($urandom); DB_IN = 8'($urandom);
        if (upd) begin
            upd_valid = 1; upd_ch = uch; upd_addr = ua; upd_count = uc;
            // CPU byte write to the same register wins; the other register takes the core value
            if (!(a < 4'h8 && !a[0] && a[2:1] == uch)) m_ca[uch] = ua;
            if (!(a < 4'h8 &&  a[0] && a[2:1] == uch)) m_cc[uch] = uc;
        end
        model_write(a, d);
        @(posedge CLK); #2;
        upd_valid = 0;
    endtask

    task automatic do_read(input logic [3:0] a);
        logic [7:0] e;
        @(posedge CLK); #2;
        temp_data = 8'($urandom);
        dreq_in = 4'($urandom);
        model_read(a, e);
        exp_rd_q.push_back(e);
        rd_issued++;
        CS_N = 0; A = a; IOR_N = 0;
        repeat (2) @(posedge CLK);
        #2;
        IOR_N = 1; CS_N = 1;
        @(posedge CLK); #2;
    endtask

    task automatic do_tc(input logic [3:0] v);
        @(posedge CLK); #2;
        tc_pulse = v;
        model_tc(v);
        @(posedge CLK); #2;
        tc_pulse = 0;
    endtask

    task automatic do_upd(input logic [1:0] ch, input logic [15:0] ua, input logic [15:0] uc);
        @(posedge CLK); #2;
        upd_valid = 1; upd_ch = ch; upd_addr = ua; upd_count = uc;
        m_ca[ch] = ua; m_cc[ch] = uc;
        @(posedge CLK); #2;
        upd_valid = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N = 0; CS_N = 1; IOR_N = 1; IOW_N = 1; A = 0; DB_IN = 0;
        dreq_in = 0; tc_pulse = 0; temp_data = 0;
        upd_valid = 0; upd_ch = 0; upd_addr = 0; upd_count = 0;
        model_reset();
        repeat (3) @(posedge CLK);
        #2 RESET_N = 1;
        push_check();

        // 16-bit address via byte pointer, read back low then high
        do_write(4'hC, 8'h00, 0, 0, 0, 0);
        do_write(4'h2, 8'h34, 0, 0, 0, 0);
        do_write(4'h2, 8'h12, 0, 0, 0, 0);
        push_check();
        do_read(4'h2);
        do_read(4'h2);

        do_write(4'hB, 8'b0101_0110, 0, 0, 0, 0);
        push_check();

        // Terminal count on a non-auto-init channel
        do_write(4'hB, 8'h02, 0, 0, 0, 0);
        do_write(4'hA, 8'h02, 0, 0, 0, 0);
        do_tc(4'b0100);
        push_check();
        do_read(4'h8);
        do_read(4'h8);

        do_write(4'hF, 8'h05, 0, 0, 0, 0);
        push_check();
        do_write(4'hE, 8'h00, 0, 0, 0, 0);
        push_check();
        do_write(4'h8, 8'hA5, 0, 0, 0, 0);
        do_write(4'h0, 8'h11, 0, 0, 0, 0);
        do_write(4'hD, 8'h00, 0, 0, 0, 0);
        push_check();
        push_check();
        do_read(4'h0);

        // Core update collides with a CPU write to the same channel's count
        do_write(4'h3, 8'h77, 1, 2'd1, 16'hABCD, 16'h5555);
        push_check();
        do_read(4'hD);
        do_read(4'hF);

        // Reset while a write strobe is active: no commit afterwards
        @(posedge CLK); #2;
        CS_N = 0; A = 4'h8; DB_IN = 8'hEE; IOW_N = 0;
        @(posedge CLK); #2 RESET_N = 0;
        @(posedge CLK); #2 IOW_N = 1; CS_N = 1;
        @(posedge CLK); #2 RESET_N = 1;
        model_reset();
        repeat (2) @(posedge CLK);
        #2;
        push_check();

        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 3))
                0: do_write(4'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0),
                            2'($urandom), 16'($urandom), 16'($urandom));
                1: do_read(4'($urandom));
                2: do_tc(4'($urandom));
                default: do_upd(2'($urandom), 16'($urandom), 16'($urandom));
            endcase
            push_check();
        end

        repeat (4) @(posedge CLK);
        chk("reads_seen", 64'(rd_seen), 64'(rd_issued));
        chk("checks_done", 64'(chk_done_n), 64'(chk_req_n));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
